fpu_sched: RTL

Shares a single `fpu` instance among `N` requesters. Arbitrates with a round-robin policy, registers the winning operands and drives the FPU inputs. Waits a per-opcode fixed latency, then captures the result and flags and returns them to the granted requester. It has one operation in flight at a time. It sits between the requesting units and the `fpu` datapath (`clk`, `rmode`, `fpu_op`, `opa`, `opb` → `out` + 8 exception flags).

---
 rtl/fpu_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_sched.sv
// fpu_sched: shares one fpu datapath among N requesters.
//   Round-robin arbitration in IDLE; the winner's operands are registered and
//   driven onto the fpu inputs for a fixed per-opcode latency, then the result
//   and flags are captured and returned to that requester.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready [N]       request handshake (req_ready one-hot grant)
//   req_op [3N], req_rmode [2N]   per-requester opcode / rounding mode
//   req_a, req_b [32N]            per-requester operands
//   rsp_valid [N], rsp_ready [N]  response handshake (rsp_valid one-hot)
//   rsp_out [32], rsp_flags [8]   captured fpu result and exception flags
//   busy                          high whenever not IDLE
//   fpu_op/fpu_rmode/fpu_opa/fpu_opb  fpu inputs (zero outside BUSY)
//   fpu_out [32], fpu_flags [8]   fpu result inputs
module fpu_sched #(
  parameter int N        = 4,
  parameter int LAT_ADD  = 4,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 28,
  parameter int LAT_MISC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [3*N-1:0]  req_op,
  input  logic [2*N-1:0]  req_rmode,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [31:0]     rsp_out,
  output logic [7:0]      rsp_flags,
  output logic            busy,
  output logic [2:0]      fpu_op,
  output logic [1:0]      fpu_rmode,
  output logic [31:0]     fpu_opa,
  output logic [31:0]     fpu_opb,
  input  logic [31:0]     fpu_out,
  input  logic [7:0]      fpu_flags
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      rmode_q, rmode_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     rsp_out_q, rsp_out_d;
  logic [7:0]      rsp_flags_q, rsp_flags_d;

  logic [IW-1:0]   win;
  logic            any_valid;
  logic            hs;
  logic [2:0]      win_op;
  logic [1:0]      win_rmode;
  logic [31:0]     win_a;
  logic [31:0]     win_b;

  function automatic logic [4:0] lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: lat_of = 5'(LAT_ADD);
      3'd2:       lat_of = 5'(LAT_MUL);
      3'd3:       lat_of = 5'(LAT_DIV);
      default:    lat_of = 5'(LAT_MISC);
    endcase
  endfunction

  // Round-robin pick: first valid index at or after ptr, wrapping modulo N.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    win       = '0;
    any_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!any_valid && req_valid[idx]) begin
        win       = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_op    = '0;
    win_rmode = '0;
    win_a     = '0;
    win_b     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win == IW'(k)) begin
        win_op    = req_op[3*k +: 3];
        win_rmode = req_rmode[2*k +: 2];
        win_a     = req_a[32*k +: 32];
        win_b     = req_b[32*k +: 32];
      end
    end
  end

  assign hs = (state_q == IDLE) && any_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      rmode_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rmode_q     <= rmode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rmode_d     = rmode_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = win_op;
          rmode_d = win_rmode;
          a_d     = win_a;
          b_d     = win_b;
          g_d     = win;
          ptr_d   = (win == IW'(N-1)) ? '0 : win + 1'b1;
          cnt_d   = lat_of(win_op);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          rsp_out_d   = fpu_out;
          rsp_flags_d = fpu_flags;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (hs) req_ready[win] = 1'b1;
    if (state_q == RESP) rsp_valid[g_q] = 1'b1;
    busy      = (state_q != IDLE);
    rsp_out   = rsp_out_q;
    rsp_flags = rsp_flags_q;
    if (state_q == BUSY) begin
      fpu_op    = op_q;
      fpu_rmode = rmode_q;
      fpu_opa   = a_q;
      fpu_opb   = b_q;
    end else begin
      fpu_op    = '0;
      fpu_rmode = '0;
      fpu_opa   = '0;
      fpu_opb   = '0;
    end
  end

endmodule
